ram_port_avl: RTL and testbench
===============================

// Module: ram_port_avl
// PURPOSE
//  Single-port responder for the frame-buffer memory handshake: accepts wr_en/rd_en
//  requests with 24-bit word addresses from frame_buf_alt and converts them into
//  single-beat Avalon-MM commands to the LPDDR2 controller. It returns read data
//  with a one-cycle rd_data_valid pulse. One instance per port inside the RAM interface.
// PARAMETERS
//  DATA_W      32         data width, frame side and Avalon side
//  ADDR_W      24         frame-side word address width
//  AVL_ADDR_W  29         Avalon word address width
//  BASE_ADDR   29'h0      port base; avl_addr = BASE_ADDR + addr, mod 2^AVL_ADDR_W
//  TIMEOUT     1023       max cycles waiting for avl_rdata_valid before rd_err
// PORTS
//  clk             in   1           single clock, all logic posedge
//  reset           in   1           async, active-low
//  wr_en           in   1           write request, sampled only when wr_rdy=1
//  wr_addr         in   ADDR_W      write word address
//  wr_data         in   DATA_W      write data
//  rd_en           in   1           read request, sampled only when rd_rdy=1
//  rd_addr         in   ADDR_W      read word address
//  wr_rdy          out  1           port can accept a write this cycle
//  rd_rdy          out  1           port can accept a read this cycle
//  rd_data         out  DATA_W      read data, held until next valid
//  rd_data_valid   out  1           one-cycle pulse, rd_data valid
//  rd_err          out  1           sticky read-timeout flag
//  avl_ready       in   1           controller accepts command this cycle
//  avl_addr        out  AVL_ADDR_W  command address
//  avl_wdata       out  DATA_W      write data
//  avl_write_req   out  1           write command
//  avl_read_req    out  1           read command
//  avl_burstbegin  out  1           high with each command (single beat)
//  avl_size        out  3           constant 3'd1
//  avl_rdata       in   DATA_W      controller read data
//  avl_rdata_valid in   1           controller read data valid
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0 except avl_size=1. rd_data=0.
//  Reset mid-transaction drops it silently; any in-flight avl_rdata_valid is ignored.
//  FSM: IDLE, WR_CMD, RD_CMD, RD_WAIT.
//  IDLE: wr_rdy=1, rd_rdy=1. wr_en=1 -> latch wr_addr/wr_data, go WR_CMD.
//   Else rd_en=1 -> latch rd_addr, go RD_CMD. wr_en and rd_en together: write wins,
//   and the read is not captured; the requester must hold rd_en.
//  WR_CMD: avl_write_req=avl_burstbegin=1 with registered addr/data. Hold until
//   avl_ready=1, then go to IDLE. Write is complete when accepted; no response.
//  RD_CMD: avl_read_req=avl_burstbegin=1. Hold until avl_ready=1, then go RD_WAIT.
//   Clear the timeout counter.
//  RD_WAIT: count cycles. avl_rdata_valid=1 -> rd_data<=avl_rdata. Next cycle
//   rd_data_valid=1 for exactly one cycle. Go IDLE.
//   Counter reaches TIMEOUT -> rd_err<=1 (sticky until reset), rd_data_valid not
//   pulsed, go IDLE.
//  wr_rdy/rd_rdy are 0 in all states except IDLE. This gives at most one outstanding
//   command and no reordering.
//  Commands are Moore outputs (registered), stable while avl_ready=0.
//  Latency: request in IDLE at cycle N -> command visible at N+1. Read:
//   avl_rdata_valid at cycle M -> rd_data_valid at M+1.
//  Address add wraps: BASE_ADDR + 24'hFFFFFF is truncated to AVL_ADDR_W bits.
//  avl_rdata_valid outside RD_WAIT is ignored.
// TESTING
//  1 wr_en, addr 0, data 32'h00FFFFFF, avl_ready=1 -> write_req 1 cycle; addr=BASE; back to IDLE.
//  2 rd_en, addr 7, ready=1, rdata_valid 5 cyc later, data 32'hA5 -> one rd_data_valid pulse, rd_data=A5.
//  3 avl_ready=0 for 10 cycles during WR_CMD -> write_req, addr, data stable; wr_rdy=0 throughout.
//  4 wr_en and rd_en same cycle -> write issued first; read issued after return to IDLE if rd_en held.
//  5 no rdata_valid after read -> rd_err=1 at TIMEOUT+1 cycles; no valid pulse; port accepts again.
//  6 reset low in RD_WAIT, then late rdata_valid -> outputs zero; no rd_data_valid pulse.

Source files
------------

// File: rtl/ram_port_avl.sv
// ram_port_avl
//   Single-port responder between the frame-buffer request handshake and the
//   LPDDR2 controller's Avalon-MM slave. Each accepted wr_en/rd_en request
//   becomes one single-beat Avalon command; read data comes back to the
//   requester as a one-cycle rd_data_valid pulse. Only one command is ever
//   outstanding, so responses can never be reordered.
//
// Ports
//   clk, reset                     clock (posedge) and async active-low reset
//   wr_en, wr_addr, wr_data        write request, taken only while wr_rdy=1
//   rd_en, rd_addr                 read request, taken only while rd_rdy=1
//   wr_rdy, rd_rdy                 port idle and able to take a request
//   rd_data, rd_data_valid         read return data and its one-cycle strobe
//   rd_err                         sticky read-timeout flag
//   avl_ready                      controller accepts the presented command
//   avl_addr, avl_wdata            command address (BASE_ADDR + word addr) / data
//   avl_write_req, avl_read_req    command strobes, held until accepted
//   avl_burstbegin, avl_size       single-beat burst marker, size fixed at 1
//   avl_rdata, avl_rdata_valid     controller read return

module ram_port_avl #(
  parameter int                    DATA_W     = 32,
  parameter int                    ADDR_W     = 24,
  parameter int                    AVL_ADDR_W = 29,
  parameter logic [AVL_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  wr_rdy,
  output logic                  rd_rdy,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_err,
  input  logic                  avl_ready,
  output logic [AVL_ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0]     avl_wdata,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic                  avl_burstbegin,
  output logic [2:0]            avl_size,
  input  logic [DATA_W-1:0]     avl_rdata,
  input  logic                  avl_rdata_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CMD  = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    rdy_q;
  logic [AVL_ADDR_W-1:0]   avl_addr_q;
  logic [DATA_W-1:0]       avl_wdata_q;
  logic                    write_req_q;
  logic                    read_req_q;
  logic                    burst_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_valid_q;
  logic                    rd_err_q;
  logic [CNT_W-1:0]        cnt_q;

  // All outputs are registered so the Avalon command stays stable while the
  // controller stalls. rdy_q is held low straight out of reset and goes high
  // on the first IDLE cycle; a request is only taken while it is already high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      avl_addr_q  <= '0;
      avl_wdata_q <= '0;
      write_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      burst_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          // Write has priority; a simultaneous read is not latched and the
          // requester keeps rd_en asserted until the port is idle again.
          if (rdy_q && wr_en) begin
            avl_addr_q  <= BASE_ADDR + AVL_ADDR_W'(wr_addr);
            avl_wdata_q <= wr_data;
            write_req_q <= 1'b1;
            burst_q     <= 1'b1;
            rdy_q       <= 1'b0;
            state_q     <= WR_CMD;
          end else if (rdy_q && rd_en) begin
            avl_addr_q <= BASE_ADDR + AVL_ADDR_W'(rd_addr);
            read_req_q <= 1'b1;
            burst_q    <= 1'b1;
            rdy_q      <= 1'b0;
            state_q    <= RD_CMD;
          end
        end
        WR_CMD: begin
          if (avl_ready) begin
            write_req_q <= 1'b0;
            burst_q     <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        RD_CMD: begin
          if (avl_ready) begin
            read_req_q <= 1'b0;
            burst_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Returned data wins over a timeout landing in the same cycle.
          if (avl_rdata_valid) begin
            rd_data_q  <= avl_rdata;
            rd_valid_q <= 1'b1;
            rdy_q      <= 1'b1;
            state_q    <= IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rd_err_q <= 1'b1;
            rdy_q    <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_rdy         = rdy_q;
  assign rd_rdy         = rdy_q;
  assign rd_data        = rd_data_q;
  assign rd_data_valid  = rd_valid_q;
  assign rd_err         = rd_err_q;
  assign avl_addr       = avl_addr_q;
  assign avl_wdata      = avl_wdata_q;
  assign avl_write_req  = write_req_q;
  assign avl_read_req   = read_req_q;
  assign avl_burstbegin = burst_q;
  assign avl_size       = 3'd1;

endmodule

// File: tb/tb_ram_port_avl.sv
// tb_ram_port_avl
//   Directed bench for ram_port_avl. Inputs are driven and outputs sampled
//   1ns after each rising edge. A small TIMEOUT keeps the timeout scenario
//   short, and a BASE_ADDR near the top of the Avalon space exercises the
//   address wrap.

module tb_ram_port_avl;

  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 24;
  localparam int          AW      = 29;
  localparam logic [28:0] BASE    = 29'h1FFF_FFF0;
  localparam int          TMO     = 16;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_rdy;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_err;
  logic              avl_ready;
  logic [AW-1:0]     avl_addr;
  logic [DATA_W-1:0] avl_wdata;
  logic              avl_write_req;
  logic              avl_read_req;
  logic              avl_burstbegin;
  logic [2:0]        avl_size;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rdata_valid;

  int vectors;
  int miscompares;

  ram_port_avl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AVL_ADDR_W(AW),
    .BASE_ADDR(BASE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_rdy(wr_rdy), .rd_rdy(rd_rdy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_err(rd_err),
    .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_burstbegin(avl_burstbegin), .avl_size(avl_size),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    avl_ready = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;

    // Reset values
    tick(); tick();
    checkOutput("rst_wr_rdy", 32'(wr_rdy), 32'd0);
    checkOutput("rst_rd_rdy", 32'(rd_rdy), 32'd0);
    checkOutput("rst_size", 32'(avl_size), 32'd1);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_wreq", 32'(avl_write_req), 32'd0);
    checkOutput("rst_addr", 32'(avl_addr), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle_wr_rdy", 32'(wr_rdy), 32'd1);
    checkOutput("idle_rd_rdy", 32'(rd_rdy), 32'd1);

    // 1: single write, immediately accepted
    wr_en = 1'b1; wr_addr = 24'h0; wr_data = 32'h00FF_FFFF; avl_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    checkOutput("t1_wreq", 32'(avl_write_req), 32'd1);
    checkOutput("t1_bb", 32'(avl_burstbegin), 32'd1);
    checkOutput("t1_addr", 32'(avl_addr), 32'h1FFF_FFF0);
    checkOutput("t1_wdata", avl_wdata, 32'h00FF_FFFF);
    checkOutput("t1_wr_rdy", 32'(wr_rdy), 32'd0);
    tick();
    checkOutput("t1_wreq_done", 32'(avl_write_req), 32'd0);
    checkOutput("t1_bb_done", 32'(avl_burstbegin), 32'd0);
    checkOutput("t1_idle", 32'(wr_rdy), 32'd1);

    // 2: read with data returning five cycles after the command is accepted
    rd_en = 1'b1; rd_addr = 24'd7;
    tick();
    rd_en = 1'b0;
    checkOutput("t2_rreq", 32'(avl_read_req), 32'd1);
    checkOutput("t2_addr", 32'(avl_addr), 32'h1FFF_FFF7);
    checkOutput("t2_rd_rdy", 32'(rd_rdy), 32'd0);
    tick();
    checkOutput("t2_rreq_done", 32'(avl_read_req), 32'd0);
    tick(); tick(); tick(); tick();
    checkOutput("t2_no_early", 32'(rd_data_valid), 32'd0);
    avl_rdata_valid = 1'b1; avl_rdata = 32'h0000_00A5;
    tick();
    avl_rdata_valid = 1'b0; avl_rdata = 32'h0;
    checkOutput("t2_valid", 32'(rd_data_valid), 32'd1);
    checkOutput("t2_data", rd_data, 32'h0000_00A5);
    checkOutput("t2_rd_rdy_back", 32'(rd_rdy), 32'd1);
    tick();
    checkOutput("t2_pulse_end", 32'(rd_data_valid), 32'd0);
    checkOutput("t2_data_held", rd_data, 32'h0000_00A5);

    // 3: controller stalls a write for 10 cycles; top address exercises wrap
    avl_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 24'hFF_FFFF; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_wreq_hold", 32'(avl_write_req), 32'd1);
      checkOutput("t3_addr_wrap", 32'(avl_addr), 32'h00FF_FFEF);
      checkOutput("t3_wdata_hold", avl_wdata, 32'hDEAD_BEEF);
      checkOutput("t3_wr_rdy_low", 32'(wr_rdy), 32'd0);
      tick();
    end
    checkOutput("t3_still_held", 32'(avl_write_req), 32'd1);
    avl_ready = 1'b1;
    tick();
    checkOutput("t3_wreq_done", 32'(avl_write_req), 32'd0);
    checkOutput("t3_idle", 32'(wr_rdy), 32'd1);

    // 4: simultaneous write and read; write first, held read follows
    wr_en = 1'b1; wr_addr = 24'd5; wr_data = 32'h0000_0011;
    rd_en = 1'b1; rd_addr = 24'd9;
    tick();
    wr_en = 1'b0;
    checkOutput("t4_wreq", 32'(avl_write_req), 32'd1);
    checkOutput("t4_no_rreq", 32'(avl_read_req), 32'd0);
    checkOutput("t4_waddr", 32'(avl_addr), 32'h1FFF_FFF5);
    tick();
    checkOutput("t4_idle_wreq", 32'(avl_write_req), 32'd0);
    checkOutput("t4_idle_rreq", 32'(avl_read_req), 32'd0);
    checkOutput("t4_idle_rdy", 32'(rd_rdy), 32'd1);
    tick();
    rd_en = 1'b0;
    checkOutput("t4_rreq", 32'(avl_read_req), 32'd1);
    checkOutput("t4_raddr", 32'(avl_addr), 32'h1FFF_FFF9);
    tick();
    avl_rdata_valid = 1'b1; avl_rdata = 32'h1234_5678;
    tick();
    avl_rdata_valid = 1'b0; avl_rdata = 32'h0;
    checkOutput("t4_valid", 32'(rd_data_valid), 32'd1);
    checkOutput("t4_data", rd_data, 32'h1234_5678);

    // 5: read never answered -> timeout
    tick();
    rd_en = 1'b1; rd_addr = 24'd3;
    tick();
    rd_en = 1'b0;
    checkOutput("t5_rreq", 32'(avl_read_req), 32'd1);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      checkOutput("t5_err_low", 32'(rd_err), 32'd0);
      checkOutput("t5_busy", 32'(rd_rdy), 32'd0);
    end
    tick();
    checkOutput("t5_err", 32'(rd_err), 32'd1);
    checkOutput("t5_no_valid", 32'(rd_data_valid), 32'd0);
    checkOutput("t5_rdy", 32'(rd_rdy), 32'd1);
    checkOutput("t5_data_kept", rd_data, 32'h1234_5678);
    wr_en = 1'b1; wr_addr = 24'd1; wr_data = 32'h2;
    tick();
    wr_en = 1'b0;
    checkOutput("t5_accept_again", 32'(avl_write_req), 32'd1);
    tick();
    checkOutput("t5_err_sticky", 32'(rd_err), 32'd1);

    // Stray read data while idle is ignored
    avl_rdata_valid = 1'b1; avl_rdata = 32'h0000_FFFF;
    tick();
    avl_rdata_valid = 1'b0; avl_rdata = 32'h0;
    checkOutput("stray_no_valid", 32'(rd_data_valid), 32'd0);
    checkOutput("stray_data_kept", rd_data, 32'h1234_5678);

    // 6: reset during RD_WAIT, late data afterwards
    rd_en = 1'b1; rd_addr = 24'd2;
    tick();
    rd_en = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_err_clr", 32'(rd_err), 32'd0);
    checkOutput("t6_data_clr", rd_data, 32'd0);
    checkOutput("t6_rdy_clr", 32'(rd_rdy), 32'd0);
    checkOutput("t6_rreq_clr", 32'(avl_read_req), 32'd0);
    tick();
    avl_rdata_valid = 1'b1; avl_rdata = 32'h0000_CAFE;
    tick();
    reset = 1'b1;
    tick();
    avl_rdata_valid = 1'b0; avl_rdata = 32'h0;
    checkOutput("t6_no_valid", 32'(rd_data_valid), 32'd0);
    checkOutput("t6_data_zero", rd_data, 32'd0);
    checkOutput("t6_rdy", 32'(rd_rdy), 32'd1);
    tick();
    checkOutput("t6_no_valid2", 32'(rd_data_valid), 32'd0);
    checkOutput("t6_no_rreq", 32'(avl_read_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
